snn_mem_loader: RTL and testbench
=================================

# snn_mem_loader

Clocked memory-side endpoint of the SNN load/result protocol. It holds the 5x5 filter and two 25x25 binary ifmaps (timesteps 1 and 2), and streams them to the NoC accelerator as START, FILTER, IFMAP and DONE tokens. It then accepts the accelerator's result stream (start, timestep, layer, 21x21 output spikes per timestep, done) into two output-spike memories. A host preloads and reads back the memories through a simple side port.

## Interface
Parameters:
- WIDTH_data, 8, filter word width
- WIDTH_addr, 12, address field width on both streams
- DEPTH_F, 5, filter side (DEPTH_F² words)
- DEPTH_I, 25, ifmap side (DEPTH_I² bits per timestep)
- DEPTH_R, 21, output side (DEPTH_R² bits per timestep)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  host write strobe; honoured only in IDLE
- cfg_sel  in  2  0 filter, 1 ifmap ts1, 2 ifmap ts2, 3 reserved (write dropped)
- cfg_addr  in  WIDTH_addr  host address
- cfg_wdata  in  WIDTH_data  host data; ifmaps store bit 0
- go  in  1  start a transaction; honoured only in IDLE
- ld_valid  out  1  load token valid
- ld_ready  in  1  accelerator accepts load token
- ld_kind  out  2  0 START, 1 FILTER, 2 IFMAP, 3 DONE
- ld_ts  out  2  timestep (IFMAP only, else 0)
- ld_addr  out  WIDTH_addr  word address
- ld_data  out  WIDTH_data  filter word, or ifmap bit zero-extended; START/DONE carry 1
- rx_valid  in  1  result token valid
- rx_ready  out  1  block accepts result token
- rx_kind  in  3  0 START, 1 TS, 2 LAYER, 3 SPIKE, 4 DONE
- rx_val  in  2  timestep (TS) or layer (LAYER)
- rx_addr  in  WIDTH_addr  spike address
- rx_data  in  13  spike value; nonzero = 1
- rd_ts  in  1  readback select: 0 ts1, 1 ts2
- rd_addr  in  WIDTH_addr  readback address
- rd_data  out  1  registered output-spike readback
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when result DONE is accepted
- err  out  1  sticky protocol/address error; cleared on accepted go
- spike_cnt1, spike_cnt2  out  9 each  count of 1-spikes stored per timestep

## Operation
- State machine: IDLE -> TX_START -> TX_FILT -> TX_IF1 -> TX_IF2 -> TX_DONE -> RX_WAIT -> RX_RUN -> IDLE.
- IDLE: rx_ready=0, ld_valid=0. go clears err, spike_cnt1, spike_cnt2 and the index counter, then moves to TX_START.
- TX_FILT: sends addr 0..24, data = filter[addr].
- TX_IF1 sends IFMAP addr 0..624 with ts=1; TX_IF2 does the same with ts=2.
- Transmit totals exactly 1+25+625+625+1 = 1277 handshakes, in strict order.
- RX_WAIT: rx_ready=1. START moves to RX_RUN; any other kind sets err and is dropped.
- RX_RUN: rx_ready=1.
  - TS latches cur_ts. Values other than 1 or 2 set err and invalidate cur_ts.
  - LAYER must equal 1, else err.
  - SPIKE writes (rx_data!=0) to out_mem[cur_ts][rx_addr] and increments spike_cnt for cur_ts when the value is 1.
  - DONE pulses done and returns to IDLE.
  - A second START is ignored.
- A SPIKE with rx_addr ≥ 441, or with cur_ts invalid, is dropped and sets err.
- Rewriting an address overwrites the stored bit. Counters count writes, not unique addresses, and saturate at 511.
- Counters are width-safe: the index counter is 10 bits; the filter/ifmap terminal is index == last, then reset to 0.

## Timing
- ld_* outputs are registered. A token transfers on a rising edge with ld_valid && ld_ready.
- ld_kind, ld_ts, ld_addr and ld_data are stable while ld_valid=1 and ld_ready=0.
- The next token is presented in the cycle after a transfer. Back-to-back transfers sustain one token per cycle.
- TX_START is entered one cycle after go. ld_valid asserts in that TX_START cycle.
- A result token is consumed on the edge with rx_valid && rx_ready. The spike write is visible on rd_data 2 cycles later (write edge + registered read).
- rd_data has 1-cycle latency from rd_ts/rd_addr. Reads are allowed in any state.
- done asserts the cycle after DONE is accepted. busy falls in that same cycle.
- Reset (any time, including mid-stream): state IDLE; ld_valid, rx_ready, done, err, busy and rd_data are 0; counters are 0; ld_kind/ld_ts/ld_addr/ld_data are 0.
- Memory contents are not cleared by reset.
- go or cfg_we arriving while busy is ignored.

## Test plan
- Preload filter[i]=i+1 and ifmap1 bit = addr odd, ifmap2 bit = addr even. Hold ld_ready=1 and pulse go -> 1277 consecutive transfers. FILTER addr 24 carries 25; IFMAP ts1 addr 3 carries 1; IFMAP ts2 addr 3 carries 0; the final transfer is DONE.
- Drive ld_ready randomly at 30% -> the token sequence is identical to the previous case, and the fields stay stable during every stall.
- Result stream START, TS=1, LAYER=1, 441 spikes with addr%3==0 set, TS=2, LAYER=1, 441 zeros, DONE -> spike_cnt1=147, spike_cnt2=0, done pulses once, readback ts1 addr 6 = 1, err=0.
- SPIKE addr 441, TS=3, or LAYER=2 each -> err=1, no memory write, counters unchanged. The next go clears err.
- Assert reset after 300 load transfers -> outputs return to their reset values. A subsequent go restarts at START with filter addr 0, and the preloaded memory content is intact.
- cfg_we and go pulsed during RX_RUN -> ignored. Filter contents are unchanged and no new transmit starts.

Source files
------------

// File: rtl/snn_mem_loader.sv
// snn_mem_loader
// Memory-side endpoint of the SNN load/result protocol.
//   - Holds a DEPTH_F x DEPTH_F filter (WIDTH_data words) and two
//     DEPTH_I x DEPTH_I binary ifmaps (timesteps 1 and 2).
//   - On go, streams START, FILTER[0..F-1], IFMAP ts1[0..I-1],
//     IFMAP ts2[0..I-1] and DONE tokens on the ld_* channel.
//   - Then accepts the result stream (START, TS, LAYER, SPIKE..., DONE) on
//     the rx_* channel into two DEPTH_R x DEPTH_R output-spike memories.
//   - Host side port: cfg_* preloads filter/ifmaps (IDLE only),
//     rd_* reads back output spikes with one cycle of latency.
//
// Ports
//   clk, reset               clock (rising edge), async active-high reset
//   cfg_we/sel/addr/wdata    host write port (sel 0 filter, 1 ifmap ts1,
//                            2 ifmap ts2, 3 dropped)
//   go                       start a transaction (IDLE only)
//   ld_valid/ready/kind/ts/addr/data   load token stream (registered)
//   rx_valid/ready/kind/val/addr/data  result token stream
//   rd_ts, rd_addr, rd_data  output-spike readback (registered)
//   busy, done, err          status: not IDLE, result DONE pulse, sticky error
//   spike_cnt1, spike_cnt2   saturating count of 1-spikes written per timestep
//
// Handshake: a token moves on a rising edge where valid && ready. A producer
// holding valid high keeps every payload field constant until that edge;
// valid never depends combinationally on ready.

module snn_mem_loader #(
    parameter int WIDTH_data = 8,
    parameter int WIDTH_addr = 12,
    parameter int DEPTH_F    = 5,
    parameter int DEPTH_I    = 25,
    parameter int DEPTH_R    = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    input  logic [WIDTH_addr-1:0] cfg_addr,
    input  logic [WIDTH_data-1:0] cfg_wdata,
    input  logic                  go,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic [1:0]            ld_kind,
    output logic [1:0]            ld_ts,
    output logic [WIDTH_addr-1:0] ld_addr,
    output logic [WIDTH_data-1:0] ld_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [2:0]            rx_kind,
    input  logic [1:0]            rx_val,
    input  logic [WIDTH_addr-1:0] rx_addr,
    input  logic [12:0]           rx_data,
    input  logic                  rd_ts,
    input  logic [WIDTH_addr-1:0] rd_addr,
    output logic                  rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [8:0]            spike_cnt1,
    output logic [8:0]            spike_cnt2
);

    localparam int F_N  = DEPTH_F * DEPTH_F;
    localparam int I_N  = DEPTH_I * DEPTH_I;
    localparam int R_N  = DEPTH_R * DEPTH_R;
    localparam int IW_F = $clog2(F_N);
    localparam int IW_I = $clog2(I_N);
    localparam int IW_R = $clog2(R_N);

    localparam logic [9:0] F_LAST = 10'(F_N - 1);
    localparam logic [9:0] I_LAST = 10'(I_N - 1);

    localparam logic [WIDTH_addr-1:0] F_LIM = WIDTH_addr'(F_N);
    localparam logic [WIDTH_addr-1:0] I_LIM = WIDTH_addr'(I_N);
    localparam logic [WIDTH_addr-1:0] R_LIM = WIDTH_addr'(R_N);

    // load token kinds
    localparam logic [1:0] LD_START  = 2'd0;
    localparam logic [1:0] LD_FILTER = 2'd1;
    localparam logic [1:0] LD_IFMAP  = 2'd2;
    localparam logic [1:0] LD_DONE   = 2'd3;

    // result token kinds
    localparam logic [2:0] RX_START = 3'd0;
    localparam logic [2:0] RX_TS    = 3'd1;
    localparam logic [2:0] RX_LAYER = 3'd2;
    localparam logic [2:0] RX_SPIKE = 3'd3;
    localparam logic [2:0] RX_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_START,
        S_TX_FILT,
        S_TX_IF1,
        S_TX_IF2,
        S_TX_DONE,
        S_RX_WAIT,
        S_RX_RUN
    } state_t;

    state_t state, state_n;
    logic [9:0] idx, idx_n;

    // storage (not reset)
    logic [WIDTH_data-1:0] filt_mem [F_N];
    logic [I_N-1:0]        if1_mem;
    logic [I_N-1:0]        if2_mem;
    logic [R_N-1:0]        out1_mem;
    logic [R_N-1:0]        out2_mem;

    // result-side timestep tracking
    logic cur_ts;     // 0 = ts1, 1 = ts2
    logic cur_ts_ok;  // a valid TS token has been seen

    logic ld_fire, rx_fire, in_idle, spike_ok, spike_one;

    // next-cycle load token, registered into ld_*
    logic                  tok_valid;
    logic [1:0]            tok_kind;
    logic [1:0]            tok_ts;
    logic [WIDTH_addr-1:0] tok_addr;
    logic [WIDTH_data-1:0] tok_data;

    assign in_idle   = (state == S_IDLE);
    assign busy      = !in_idle;
    assign rx_ready  = (state == S_RX_WAIT) || (state == S_RX_RUN);
    assign ld_fire   = ld_valid && ld_ready;
    assign rx_fire   = rx_valid && rx_ready;
    assign spike_ok  = cur_ts_ok && (rx_addr < R_LIM);
    assign spike_one = (rx_data != 13'd0);

    // next state / index
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_n = S_TX_START;
                    idx_n   = 10'd0;
                end
            end
            S_TX_START: begin
                if (ld_fire) begin
                    state_n = S_TX_FILT;
                    idx_n   = 10'd0;
                end
            end
            S_TX_FILT: begin
                if (ld_fire) begin
                    if (idx == F_LAST) begin
                        state_n = S_TX_IF1;
                        idx_n   = 10'd0;
                    end else begin
                        idx_n = idx + 10'd1;
                    end
                end
            end
            S_TX_IF1: begin
                if (ld_fire) begin
                    if (idx == I_LAST) begin
                        state_n = S_TX_IF2;
                        idx_n   = 10'd0;
                    end else begin
                        idx_n = idx + 10'd1;
                    end
                end
            end
            S_TX_IF2: begin
                if (ld_fire) begin
                    if (idx == I_LAST) begin
                        state_n = S_TX_DONE;
                        idx_n   = 10'd0;
                    end else begin
                        idx_n = idx + 10'd1;
                    end
                end
            end
            S_TX_DONE: begin
                if (ld_fire) state_n = S_RX_WAIT;
            end
            S_RX_WAIT: begin
                if (rx_fire && (rx_kind == RX_START)) state_n = S_RX_RUN;
            end
            S_RX_RUN: begin
                if (rx_fire && (rx_kind == RX_DONE)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // The token is a pure function of (state_n, idx_n). Holding state/idx
    // during a stall therefore holds the payload, and memories cannot change
    // outside IDLE, so the fields stay stable without extra hold logic.
    always_comb begin
        tok_valid = 1'b0;
        tok_kind  = LD_START;
        tok_ts    = 2'd0;
        tok_addr  = '0;
        tok_data  = '0;
        case (state_n)
            S_TX_START: begin
                tok_valid = 1'b1;
                tok_kind  = LD_START;
                tok_data  = WIDTH_data'(1);
            end
            S_TX_FILT: begin
                tok_valid = 1'b1;
                tok_kind  = LD_FILTER;
                tok_addr  = WIDTH_addr'(idx_n);
                tok_data  = filt_mem[idx_n[IW_F-1:0]];
            end
            S_TX_IF1: begin
                tok_valid = 1'b1;
                tok_kind  = LD_IFMAP;
                tok_ts    = 2'd1;
                tok_addr  = WIDTH_addr'(idx_n);
                tok_data  = {{(WIDTH_data-1){1'b0}}, if1_mem[idx_n[IW_I-1:0]]};
            end
            S_TX_IF2: begin
                tok_valid = 1'b1;
                tok_kind  = LD_IFMAP;
                tok_ts    = 2'd2;
                tok_addr  = WIDTH_addr'(idx_n);
                tok_data  = {{(WIDTH_data-1){1'b0}}, if2_mem[idx_n[IW_I-1:0]]};
            end
            S_TX_DONE: begin
                tok_valid = 1'b1;
                tok_kind  = LD_DONE;
                tok_data  = WIDTH_data'(1);
            end
            default: ;
        endcase
    end

    // control and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 10'd0;
            ld_valid   <= 1'b0;
            ld_kind    <= 2'd0;
            ld_ts      <= 2'd0;
            ld_addr    <= '0;
            ld_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            spike_cnt1 <= 9'd0;
            spike_cnt2 <= 9'd0;
            cur_ts     <= 1'b0;
            cur_ts_ok  <= 1'b0;
            rd_data    <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            ld_valid <= tok_valid;
            ld_kind  <= tok_kind;
            ld_ts    <= tok_ts;
            ld_addr  <= tok_addr;
            ld_data  <= tok_data;
            done     <= 1'b0;

            if (rd_addr < R_LIM) begin
                rd_data <= rd_ts ? out2_mem[rd_addr[IW_R-1:0]]
                                 : out1_mem[rd_addr[IW_R-1:0]];
            end else begin
                rd_data <= 1'b0;
            end

            if (in_idle && go) begin
                err        <= 1'b0;
                spike_cnt1 <= 9'd0;
                spike_cnt2 <= 9'd0;
                cur_ts_ok  <= 1'b0;
            end

            if (rx_fire && (state == S_RX_WAIT)) begin
                if (rx_kind != RX_START) err <= 1'b1;
            end

            if (rx_fire && (state == S_RX_RUN)) begin
                case (rx_kind)
                    RX_START: ;  // duplicate START is harmless
                    RX_TS: begin
                        if ((rx_val == 2'd1) || (rx_val == 2'd2)) begin
                            cur_ts    <= (rx_val == 2'd2);
                            cur_ts_ok <= 1'b1;
                        end else begin
                            cur_ts_ok <= 1'b0;
                            err       <= 1'b1;
                        end
                    end
                    RX_LAYER: begin
                        if (rx_val != 2'd1) err <= 1'b1;
                    end
                    RX_SPIKE: begin
                        if (!spike_ok) begin
                            err <= 1'b1;
                        end else if (spike_one) begin
                            if (!cur_ts) begin
                                if (spike_cnt1 != 9'h1FF) spike_cnt1 <= spike_cnt1 + 9'd1;
                            end else begin
                                if (spike_cnt2 != 9'h1FF) spike_cnt2 <= spike_cnt2 + 9'd1;
                            end
                        end
                    end
                    RX_DONE: done <= 1'b1;
                    default: err <= 1'b1;
                endcase
            end
        end
    end

    // memories: host preload in IDLE, spike writes in RX_RUN
    always_ff @(posedge clk) begin
        if (in_idle && cfg_we) begin
            case (cfg_sel)
                2'd0: if (cfg_addr < F_LIM) filt_mem[cfg_addr[IW_F-1:0]] <= cfg_wdata;
                2'd1: if (cfg_addr < I_LIM) if1_mem[cfg_addr[IW_I-1:0]] <= cfg_wdata[0];
                2'd2: if (cfg_addr < I_LIM) if2_mem[cfg_addr[IW_I-1:0]] <= cfg_wdata[0];
                default: ;
            endcase
        end
        if (rx_fire && (state == S_RX_RUN) && (rx_kind == RX_SPIKE) && spike_ok) begin
            if (!cur_ts) out1_mem[rx_addr[IW_R-1:0]] <= spike_one;
            else         out2_mem[rx_addr[IW_R-1:0]] <= spike_one;
        end
    end

endmodule

// File: tb/tb_snn_mem_loader.sv
// Directed bench for snn_mem_loader: preload, full load streams (back-to-back
// and stalled), result streams with good and bad tokens, mid-stream reset,
// and host accesses while busy.

module tb_snn_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [11:0] cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        go;
    logic        ld_valid;
    logic        ld_ready;
    logic [1:0]  ld_kind;
    logic [1:0]  ld_ts;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  rx_kind;
    logic [1:0]  rx_val;
    logic [11:0] rx_addr;
    logic [12:0] rx_data;
    logic        rd_ts;
    logic [11:0] rd_addr;
    logic        rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  spike_cnt1;
    logic [8:0]  spike_cnt2;

    int n_cmp = 0;
    int n_err = 0;
    int done_pulses = 0;

    localparam int N_TOK = 1277;

    snn_mem_loader dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .go(go),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_kind(ld_kind), .ld_ts(ld_ts),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_kind(rx_kind), .rx_val(rx_val),
        .rx_addr(rx_addr), .rx_data(rx_data),
        .rd_ts(rd_ts), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .spike_cnt1(spike_cnt1), .spike_cnt2(spike_cnt2)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected load token k as {kind, ts, addr, data}
    function automatic logic [23:0] exp_tok(input int k);
        int a;
        if (k == 0) return {2'd0, 2'd0, 12'd0, 8'd1};
        if (k <= 25) begin
            a = k - 1;
            return {2'd1, 2'd0, 12'(a), 8'(k)};
        end
        if (k <= 650) begin
            a = k - 26;
            return {2'd2, 2'd1, 12'(a), 8'(a % 2)};
        end
        if (k <= 1275) begin
            a = k - 651;
            return {2'd2, 2'd2, 12'(a), 8'((a + 1) % 2)};
        end
        return {2'd3, 2'd0, 12'd0, 8'd1};
    endfunction

    // all tasks are entered and left at a falling edge
    task automatic cfg_write(input logic [1:0] sel, input int addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = 12'(addr);
        cfg_wdata = data;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // pulse go, then accept max_x tokens with ld_ready high pct% of cycles,
    // checking the presented token against the model every valid cycle
    task automatic do_load(input int pct, input int max_x);
        int k;
        int cyc;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 0;
        cyc = 0;
        while (k < max_x && cyc < 20000) begin
            ld_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            #1;
            if (pct >= 100) check("ld_b2b_valid", 32'(ld_valid), 32'd1);
            if (ld_valid === 1'b1) begin
                check("ld_token", {8'd0, ld_kind, ld_ts, ld_addr, ld_data}, {8'd0, exp_tok(k)});
                if (ld_ready) k++;
            end
            @(negedge clk);
            cyc++;
        end
        check("ld_xfer_count", 32'(k), 32'(max_x));
        ld_ready = 1'b0;
    endtask

    task automatic send_rx(input logic [2:0] kind, input logic [1:0] val,
                           input int addr, input logic [12:0] data);
        int cyc;
        rx_valid = 1'b1;
        rx_kind  = kind;
        rx_val   = val;
        rx_addr  = 12'(addr);
        rx_data  = data;
        cyc = 0;
        while (rx_ready !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 8) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic read_spike(input string tag, input logic ts, input int addr, input logic exp);
        rd_ts   = ts;
        rd_addr = 12'(addr);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic send_done_and_check();
        send_rx(3'd4, 2'd0, 0, 13'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_clears", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_addr = '0; cfg_wdata = '0;
        go = 1'b0; ld_ready = 1'b0; rx_valid = 1'b0; rx_kind = '0; rx_val = '0;
        rx_addr = '0; rx_data = '0; rd_ts = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ld_valid", 32'(ld_valid), 32'd0);
        check("rst_ld_fields", {8'd0, ld_kind, ld_ts, ld_addr, ld_data}, 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_done", {30'd0, err, done}, 32'd0);
        check("rst_cnts", {14'd0, spike_cnt1, spike_cnt2}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // preload
        for (int i = 0; i < 25; i++) cfg_write(2'd0, i, 8'(i + 1));
        for (int i = 0; i < 625; i++) cfg_write(2'd1, i, 8'(i % 2));
        for (int i = 0; i < 625; i++) cfg_write(2'd2, i, 8'((i + 1) % 2));

        // T1: back-to-back load, then a clean result stream
        do_load(100, N_TOK);
        check("t1_ld_idle", 32'(ld_valid), 32'd0);
        check("t1_rx_ready", 32'(rx_ready), 32'd1);
        done_pulses = 0;
        send_rx(3'd0, 2'd0, 0, 13'd0);
        send_rx(3'd1, 2'd1, 0, 13'd0);
        send_rx(3'd2, 2'd1, 0, 13'd0);
        for (int a = 0; a < 441; a++) send_rx(3'd3, 2'd0, a, (a % 3 == 0) ? 13'd1 : 13'd0);
        send_rx(3'd1, 2'd2, 0, 13'd0);
        send_rx(3'd2, 2'd1, 0, 13'd0);
        for (int a = 0; a < 441; a++) send_rx(3'd3, 2'd0, a, 13'd0);
        send_done_and_check();
        check("t1_cnt1", 32'(spike_cnt1), 32'd147);
        check("t1_cnt2", 32'(spike_cnt2), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        check("t1_done_once", 32'(done_pulses), 32'd1);
        read_spike("t1_rd_ts1_a6", 1'b0, 6, 1'b1);
        read_spike("t1_rd_ts1_a7", 1'b0, 7, 1'b0);
        read_spike("t1_rd_ts2_a6", 1'b1, 6, 1'b0);

        // T2: stalled load; out-of-range spike address
        do_load(30, N_TOK);
        check("t2_cnt_cleared", 32'(spike_cnt1), 32'd0);
        send_rx(3'd0, 2'd0, 0, 13'd0);
        send_rx(3'd1, 2'd1, 0, 13'd0);
        send_rx(3'd2, 2'd1, 0, 13'd0);
        rd_ts = 1'b0;
        rd_addr = 12'd13;
        send_rx(3'd3, 2'd0, 13, 13'd7);
        check("t2_rd_latency_old", 32'(rd_data), 32'd0);
        @(negedge clk);
        check("t2_rd_latency_new", 32'(rd_data), 32'd1);
        check("t2_cnt1_one", 32'(spike_cnt1), 32'd1);
        check("t2_err_clean", 32'(err), 32'd0);
        send_rx(3'd3, 2'd0, 441, 13'd1);
        check("t2_err_addr441", 32'(err), 32'd1);
        check("t2_cnt1_hold", 32'(spike_cnt1), 32'd1);
        send_done_and_check();

        // T3: bad layer
        do_load(100, N_TOK);
        check("t3_err_cleared", 32'(err), 32'd0);
        send_rx(3'd0, 2'd0, 0, 13'd0);
        send_rx(3'd1, 2'd1, 0, 13'd0);
        send_rx(3'd2, 2'd2, 0, 13'd0);
        check("t3_err_layer2", 32'(err), 32'd1);
        send_done_and_check();

        // T4: bad timestep, following spike dropped
        do_load(100, N_TOK);
        check("t4_err_cleared", 32'(err), 32'd0);
        send_rx(3'd0, 2'd0, 0, 13'd0);
        send_rx(3'd1, 2'd3, 0, 13'd0);
        check("t4_err_ts3", 32'(err), 32'd1);
        send_rx(3'd3, 2'd0, 10, 13'd1);
        check("t4_cnts_hold", {14'd0, spike_cnt1, spike_cnt2}, 32'd0);
        send_done_and_check();
        read_spike("t4_rd_ts1_a10", 1'b0, 10, 1'b0);
        read_spike("t4_rd_ts2_a10", 1'b1, 10, 1'b0);

        // T5: reset after 300 transfers
        read_spike("t5_rd_pre", 1'b0, 6, 1'b1);
        do_load(100, 300);
        reset = 1'b1;
        #1;
        check("t5_rst_ld_valid", 32'(ld_valid), 32'd0);
        check("t5_rst_ld_fields", {8'd0, ld_kind, ld_ts, ld_addr, ld_data}, 32'd0);
        check("t5_rst_busy_rx", {30'd0, busy, rx_ready}, 32'd0);
        check("t5_rst_rd_data", 32'(rd_data), 32'd0);
        check("t5_rst_err_done", {30'd0, err, done}, 32'd0);
        @(negedge clk);
        check("t5_rst_rd_held", 32'(rd_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        do_load(100, N_TOK);

        // host write and go during RX_RUN are ignored
        send_rx(3'd0, 2'd0, 0, 13'd0);
        cfg_write(2'd0, 0, 8'hAA);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        check("t5_busy_hold", 32'(busy), 32'd1);
        check("t5_no_new_tx", 32'(ld_valid), 32'd0);
        check("t5_rx_ready_hold", 32'(rx_ready), 32'd1);
        send_done_and_check();

        // T6: filter content still intact
        do_load(100, N_TOK);
        check("t6_rx_ready", 32'(rx_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
